// File: rtl/fpu_result_pack.sv
// fpu_result_pack: output stage of the FPU add/sub datapath.
// Rounds the normal-path mantissa to nearest-even, resolves the special-case
// select codes, detects overflow/underflow and packs an IEEE-754 single word.
// The datapath is a two-stage valid/ready pipeline (round, then pack).
// Optional build macro FPU_PACK_EXC_CNT_EN adds saturating exception counters.
module fpu_result_pack #(
  parameter logic [31:0] QNAN_WORD = 32'h7FC0_0000,
  parameter int          CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_sel_man,
  input  logic               i_sign,
  input  logic signed [9:0]  i_exp,
  input  logic [26:0]        i_man,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [31:0]        o_result,
  output logic               o_flag_ovf,
  output logic               o_flag_udf,
  output logic               o_flag_nan,
`ifdef FPU_PACK_EXC_CNT_EN
  output logic [CNT_W-1:0]   o_cnt_ovf,
  output logic [CNT_W-1:0]   o_cnt_udf,
  output logic [CNT_W-1:0]   o_cnt_nan,
`endif
  input  logic               i_flag_clr
);

  typedef logic [CNT_W-1:0] cnt_t;

  // Round-to-nearest-even on {frac,G,R,S}; a carry out of the fraction
  // renormalises to 1.000..0 and bumps the exponent (10-bit wrap).
  function automatic logic [32:0] round_rne(input logic signed [9:0] exp,
                                            input logic [25:0]        man);
    logic              rnd_up;
    logic [23:0]       sum;
    logic signed [9:0] e;
    rnd_up = man[2] & (man[1] | man[0] | man[3]);
    sum    = {1'b0, man[25:3]} + {23'd0, rnd_up};
    e      = exp;
    if (sum[23]) begin
      sum = 24'd0;
      e   = exp + 10'sd1;
    end
    return {e, sum[22:0]};
  endfunction

  // Final word selection with overflow saturation to infinity and
  // underflow flush to zero; returns {nan, ovf, udf, word}.
  function automatic logic [34:0] pack_word(input logic [1:0]        sel,
                                            input logic              sign,
                                            input logic signed [9:0] exp,
                                            input logic [22:0]       frac,
                                            input logic              zero);
    logic [31:0] word;
    logic        nan, ovf, udf;
    word = {sign, exp[7:0], frac};
    nan  = 1'b0;
    ovf  = 1'b0;
    udf  = 1'b0;
    if (sel == 2'b11) begin
      word = QNAN_WORD;
      nan  = 1'b1;
    end else if (sel == 2'b10) begin
      word = {sign, 8'hFF, 23'h0};
    end else if (zero) begin
      word = {sign, 31'h0};
    end else if (exp >= 10'sd255) begin
      word = {sign, 8'hFF, 23'h0};
      ovf  = 1'b1;
    end else if (exp <= 10'sd0) begin
      word = {sign, 31'h0};
      udf  = 1'b1;
    end
    return {nan, ovf, udf, word};
  endfunction

  logic              vld_p1, vld_p2;
  logic [1:0]        sel_p1;
  logic              sign_p1;
  logic signed [9:0] exp_p1;
  logic [22:0]       frac_p1;
  logic              zero_p1;
  logic [31:0]       res_p2;

  logic [32:0]       rnd_w;
  logic [34:0]       pk_w;
  logic              adv_p2, accept, load_p2;
  logic              set_ovf, set_udf, set_nan;

  assign adv_p2  = ~vld_p2 | i_ready;
  assign o_ready = ~vld_p1 | adv_p2;
  assign accept  = i_valid & o_ready;
  assign load_p2 = vld_p1 & adv_p2;

  assign rnd_w   = round_rne(i_exp, i_man[25:0]);
  assign pk_w    = pack_word(sel_p1, sign_p1, exp_p1, frac_p1, zero_p1);
  assign set_nan = load_p2 & pk_w[34];
  assign set_ovf = load_p2 & pk_w[33];
  assign set_udf = load_p2 & pk_w[32];

  assign o_valid  = vld_p2;
  assign o_result = res_p2;

  // Stage valids: s1 refills whenever it can hand off, s2 whenever it drains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (o_ready) vld_p1 <= i_valid;
      if (adv_p2)  vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: rounded mantissa/exponent, select code and sign ----
  // Round-stage data captured on accept only.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sel_p1  <= i_sel_man;
      sign_p1 <= i_sign;
      exp_p1  <= rnd_w[32:23];
      frac_p1 <= rnd_w[22:0];
      zero_p1 <= (i_man == 27'd0);
    end
  end

  // ---- stage 2: packed IEEE word presented on o_result ----
  // Packed result loads when s1 moves forward; held while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     res_p2 <= 32'd0;
    else if (load_p2) res_p2 <= pk_w[31:0];
  end

  // Sticky flags: a set event in the same cycle as clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_flag_ovf <= 1'b0;
      o_flag_udf <= 1'b0;
      o_flag_nan <= 1'b0;
    end else begin
      o_flag_ovf <= (o_flag_ovf & ~i_flag_clr) | set_ovf;
      o_flag_udf <= (o_flag_udf & ~i_flag_clr) | set_udf;
      o_flag_nan <= (o_flag_nan & ~i_flag_clr) | set_nan;
    end
  end

`ifdef FPU_PACK_EXC_CNT_EN
  function automatic cnt_t cnt_next(input cnt_t cur, input logic set, input logic clr);
    cnt_t nxt;
    nxt = cur;
    if (set) nxt = clr ? cnt_t'(1) : ((&cur) ? cur : cur + cnt_t'(1));
    else if (clr) nxt = '0;
    return nxt;
  endfunction

  // Saturating exception counters tracking the sticky flag events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_ovf <= '0;
      o_cnt_udf <= '0;
      o_cnt_nan <= '0;
    end else begin
      o_cnt_ovf <= cnt_next(o_cnt_ovf, set_ovf, i_flag_clr);
      o_cnt_udf <= cnt_next(o_cnt_udf, set_udf, i_flag_clr);
      o_cnt_nan <= cnt_next(o_cnt_nan, set_nan, i_flag_clr);
    end
  end
`endif

endmodule
